// File: rtl/mem_subsystem_if.sv
// CPU-side strobes and status of the memory stage, grouped for port binding.
// addr_err exists only when ADDR_CHECK_EN is defined.
interface mem_subsystem_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] bus_in;
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              ramWE;
  logic [DATA_W-1:0] mdr_out;
  logic [DATA_W-1:0] mar_out;
  logic              busy;
  logic              done;
`ifdef ADDR_CHECK_EN
  logic              addr_err;

  modport master (output bus_in, MARin, MDRin, Read, ramWE,
                  input  mdr_out, mar_out, busy, done, addr_err);
  modport slave  (input  bus_in, MARin, MDRin, Read, ramWE,
                  output mdr_out, mar_out, busy, done, addr_err);
`else
  modport master (output bus_in, MARin, MDRin, Read, ramWE,
                  input  mdr_out, mar_out, busy, done);
  modport slave  (input  bus_in, MARin, MDRin, Read, ramWE,
                  output mdr_out, mar_out, busy, done);
`endif
endinterface

// File: rtl/mem_subsystem.sv
// MAR/MDR registers plus a single-port word RAM with multi-cycle edge-triggered accesses.
// Optional feature macro: ADDR_CHECK_EN (flags and suppresses out-of-range MAR accesses).
//
// Handshake: Read/ramWE are levels; only a rising edge seen in IDLE starts an access.
// busy is high in WAIT and ACCESS, done pulses for one cycle in DONE; edges outside
// IDLE are dropped, so the sequencer must lower and re-raise the strobe for another access.
module mem_subsystem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_subsystem_if.slave    bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam int          WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_LAST);

  state_t            state;
  logic [2:0]        wait_cnt;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_wr_q;
  logic              busy_r;
  logic              done_r;
  logic              access_ok;
  logic              rd_edge;
  logic              wr_edge;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  assign rd_edge = bus.Read  & ~rd_q;
  assign wr_edge = bus.ramWE & ~wr_q;

`ifdef ADDR_CHECK_EN
  logic err_q;
  logic err_sticky;
  assign access_ok    = ~err_q;
  assign bus.addr_err = err_sticky;
`else
  assign access_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mar      <= '0;
      mdr      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef ADDR_CHECK_EN
      err_q      <= 1'b0;
      err_sticky <= 1'b0;
`endif
    end else begin
      rd_q <= bus.Read;
      wr_q <= bus.ramWE;
      if (bus.MARin) mar <= bus.bus_in;
      case (state)
        S_IDLE: begin
          if (bus.MDRin) mdr <= bus.bus_in;
          if (rd_edge || wr_edge) begin
            // Snapshot address/data so later MARin/MDRin cannot disturb the access.
            addr_q   <= mar[ADDR_W-1:0];
            wdata_q  <= mdr;
            op_wr_q  <= wr_edge;
            wait_cnt <= WAIT_LOAD;
            busy_r   <= 1'b1;
            state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
`ifdef ADDR_CHECK_EN
            err_q <= |mar[DATA_W-1:ADDR_W];
            if (|mar[DATA_W-1:ADDR_W]) err_sticky <= 1'b1;
`endif
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) state <= S_ACCESS;
          else wait_cnt <= wait_cnt - 3'd1;
        end
        S_ACCESS: begin
          if (!op_wr_q) mdr <= access_ok ? ram[addr_q] : '0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (bus.MDRin) mdr <= bus.bus_in;
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A reset edge aborts an access in flight, so the write is gated by rst.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && op_wr_q && access_ok) ram[addr_q] <= wdata_q;
  end

  assign bus.mdr_out = mdr;
  assign bus.mar_out = mar;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mem_subsystem.sv
// Self-checking bench for mem_subsystem: directed scenarios plus random traffic
// against a cycle-count transaction model; a second instance covers WAIT_CYCLES=0.
module tb_mem_subsystem;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg, state_dbg0;

  mem_subsystem_if #(.DATA_W(DW)) mif ();
  mem_subsystem_if #(.DATA_W(DW)) mif0 ();

  mem_subsystem #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(mif), .state_dbg(state_dbg));
  mem_subsystem #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(mif0), .state_dbg(state_dbg0));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Drive values for the main instance; the model reads these, never the DUT.
  logic          marin_v, mdrin_v, rd_v, wr_v;
  logic [DW-1:0] bus_v;

  // Transaction-level reference model: t counts cycles since acceptance (-1 = idle).
  logic [DW-1:0] m_mar, m_mdr, a_data;
  logic [DW-1:0] m_mem [int];
  bit            m_prev_rd, m_prev_wr, a_wr, a_err, m_err;
  int            t, a_idx;
  logic [DW-1:0] last_mdr;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit rd_e, wr_e;
    logic [DW-1:0] old_mar, old_mdr;
    if (rst) begin
      m_mar = '0; m_mdr = '0; t = -1; m_prev_rd = 0; m_prev_wr = 0; m_err = 0;
      return;
    end
    rd_e = rd_v && !m_prev_rd;
    wr_e = wr_v && !m_prev_wr;
    old_mar = m_mar;
    old_mdr = m_mdr;
    if (t == W + 1) begin
      if (a_wr) begin
        if (!a_err) m_mem[a_idx] = a_data;
      end else begin
        m_mdr = a_err ? '0 : m_mem[a_idx];
      end
    end
    if ((t == -1 || t == W + 2) && mdrin_v) m_mdr = bus_v;
    if (t == -1) begin
      if (rd_e || wr_e) begin
        a_idx  = int'(old_mar % (1 << AW));
        a_data = old_mdr;
        a_wr   = wr_e;
`ifdef ADDR_CHECK_EN
        a_err  = (old_mar >> AW) != 0;
`else
        a_err  = 0;
`endif
        m_err  = m_err | a_err;
        t = 1;
      end
    end else if (t == W + 2) begin
      t = -1;
    end else begin
      t = t + 1;
    end
    if (marin_v) m_mar = bus_v;
    m_prev_rd = rd_v;
    m_prev_wr = wr_v;
  endtask

  // One clock: drive, advance model at the edge, compare on the falling edge.
  task automatic cyc();
    mif.MARin = marin_v; mif.MDRin = mdrin_v; mif.Read = rd_v; mif.ramWE = wr_v; mif.bus_in = bus_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("mdr_out", mif.mdr_out, m_mdr);
    check_val("mar_out", mif.mar_out, m_mar);
    check_val("busy", DW'(mif.busy), DW'(t >= 1 && t <= W + 1));
    check_val("done", DW'(mif.done), DW'(t == W + 2));
`ifdef ADDR_CHECK_EN
    check_val("addr_err", DW'(mif.addr_err), DW'(m_err));
`endif
  endtask

  task automatic idle_inputs();
    marin_v = 0; mdrin_v = 0; rd_v = 0; wr_v = 0; bus_v = '0;
  endtask

  // Caller has raised Read and/or ramWE; counts samples up to done inclusive.
  task automatic run_req(input string tag, input int exp_n);
    int n;
    cyc();
    n = 1;
    while (!mif.done && n < 20) begin
      cyc();
      n++;
    end
    last_mdr = mif.mdr_out;
    check_val(tag, DW'(n), DW'(exp_n));
    rd_v = 0; wr_v = 0;
    cyc();
  endtask

  task automatic load_regs(input logic [DW-1:0] addr, input logic [DW-1:0] data);
    marin_v = 1; bus_v = addr; cyc();
    marin_v = 0; mdrin_v = 1; bus_v = data; cyc();
    mdrin_v = 0;
  endtask

  task automatic write_word(input logic [DW-1:0] addr, input logic [DW-1:0] data);
    load_regs(addr, data);
    wr_v = 1;
    run_req("wr_latency", W + 2);
  endtask

  task automatic read_word(input logic [DW-1:0] addr);
    load_regs(addr, '0);
    rd_v = 1;
    run_req("rd_latency", W + 2);
  endtask

  task automatic cyc0(input logic mi, input logic di, input logic r, input logic w, input logic [DW-1:0] b);
    mif0.MARin = mi; mif0.MDRin = di; mif0.Read = r; mif0.ramWE = w; mif0.bus_in = b;
    cyc();
  endtask

  initial begin
    int n, dones;
    idle_inputs();
    mif0.MARin = 0; mif0.MDRin = 0; mif0.Read = 0; mif0.ramWE = 0; mif0.bus_in = '0;
    rst = 1; cyc(); cyc();
    check_val("rst_mar", mif.mar_out, '0);
    check_val("rst_mdr", mif.mdr_out, '0);
    check_val("rst_busy", DW'(mif.busy), '0);
    rst = 0; cyc();

    for (int i = 0; i < 16; i++) write_word(DW'(i), $urandom());

    // Write 0xDEADBEEF to 5, then read it back while disturbing MAR and Read mid-flight.
    write_word(32'd5, 32'hDEADBEEF);
    load_regs(32'd5, 32'h0);
    rd_v = 1; cyc();
    rd_v = 0; marin_v = 1; bus_v = 32'd9; cyc();
    marin_v = 0; rd_v = 1; cyc();
    cyc();
    check_val("rd_done_n4", DW'(mif.done), 32'd1);
    check_val("rd_latched_addr", mif.mdr_out, 32'hDEADBEEF);
    dones = 0;
    for (int i = 0; i < 6; i++) begin cyc(); dones += int'(mif.done); end
    check_val("second_edge_dropped", DW'(dones), 32'd0);
    rd_v = 0; cyc();

    // Simultaneous edges: write wins, MDR untouched, one done.
    load_regs(32'd7, 32'h12345678);
    rd_v = 1; wr_v = 1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin cyc(); dones += int'(mif.done); end
    check_val("simul_one_done", DW'(dones), 32'd1);
    check_val("simul_mdr_kept", mif.mdr_out, 32'h12345678);
    rd_v = 0; wr_v = 0; cyc();
    read_word(32'd7);
    check_val("simul_ram7", last_mdr, 32'h12345678);

    // Reset during ACCESS of a write must leave RAM[3] intact.
    write_word(32'd3, 32'h33333333);
    load_regs(32'd3, 32'hAAAA5555);
    wr_v = 1; cyc(); cyc(); cyc();
    rst = 1; cyc();
    check_val("abort_mar", mif.mar_out, '0);
    check_val("abort_mdr", mif.mdr_out, '0);
    check_val("abort_busy", DW'(mif.busy), '0);
    check_val("abort_done", DW'(mif.done), '0);
    rst = 0; wr_v = 0; cyc();
    read_word(32'd3);
    check_val("abort_ram3", last_mdr, 32'h33333333);

    // Out-of-range MAR: wraps to index 0 unless the address check is built in.
    write_word(32'd0, 32'h00001111);
    write_word(32'h00000200, 32'hCAFE0001);
    read_word(32'd0);
`ifdef ADDR_CHECK_EN
    check_val("oob_err", DW'(mif.addr_err), 32'd1);
    check_val("oob_ram0", last_mdr, 32'h00001111);
`else
    check_val("wrap_ram0", last_mdr, 32'hCAFE0001);
`endif

    // Random traffic; MAR mostly kept inside the initialised window.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      marin_v = ($urandom_range(0, 7) == 0);
      mdrin_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) rd_v = ~rd_v;
      if ($urandom_range(0, 3) == 0) wr_v = ~wr_v;
      bus_v = $urandom();
      if (marin_v) begin
        if ($urandom_range(0, 5) != 0) bus_v[DW-1:AW] = '0;
        bus_v[AW-1:0] = AW'($urandom_range(0, 15));
      end
      cyc();
    end
    rst = 0; idle_inputs();
    for (int i = 0; i < 6; i++) cyc();

    // Zero-wait instance: access in the cycle after acceptance, done one cycle later.
    cyc0(1, 0, 0, 0, 32'd2);
    cyc0(0, 1, 0, 0, 32'h0BADF00D);
    cyc0(0, 0, 0, 1, '0);
    check_val("w0_busy", DW'(mif0.busy), 32'd1);
    cyc0(0, 0, 0, 1, '0);
    check_val("w0_wr_done", DW'(mif0.done), 32'd1);
    cyc0(0, 1, 0, 0, '0);
    cyc0(0, 0, 1, 0, '0);
    n = 1;
    while (!mif0.done && n < 20) begin cyc0(0, 0, 1, 0, '0); n++; end
    check_val("w0_rd_latency", DW'(n), 32'd2);
    check_val("w0_rd_data", mif0.mdr_out, 32'h0BADF00D);
    cyc0(0, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
